// File: rtl/multi_cyl_injection_ctrl.sv
// Multi-cylinder fuel injection controller: prime/run/stall FSM plus NUM_CYL independent pulse timers.
// Optional feature macro INJ_DEADTIME_EN: effective width = pulse_width + dead_time (saturating).
module multi_cyl_injection_ctrl #(
    parameter int NUM_CYL      = 4,
    parameter int PW_W         = 16,
    parameter int PRIME_CYCLES = 1000,
    parameter int STALL_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 on,
    input  logic [1:0]           stroke,
    input  logic                 crank_tick,
    input  logic [2*NUM_CYL-1:0] phase_offset,
    input  logic [PW_W-1:0]      pulse_width,
    input  logic [PW_W-1:0]      dead_time,
    output logic [NUM_CYL-1:0]   inj_out,
    output logic                 fuel_pump,
    output logic                 cal_injection,
    output logic                 update_table,
    output logic [NUM_CYL-1:0]   overrun,
    output logic                 stalled
);
    localparam int PC_W = $clog2(PRIME_CYCLES + 1);
    localparam int SC_W = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STALL} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    prime_cnt_q, prime_cnt_d;
    logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [1:0]         stroke_q;
    logic               fuel_pump_q, stalled_q, cal_injection_q, update_table_q;
    logic [NUM_CYL-1:0] overrun_q, overrun_d;
    logic [NUM_CYL-1:0] trig, chan_open;
    logic [PW_W-1:0]    eff_width;
    logic               stroke_edge, run_next;

`ifdef INJ_DEADTIME_EN
    logic [PW_W:0] width_sum;
    assign width_sum = {1'b0, pulse_width} + {1'b0, dead_time};
    assign eff_width = width_sum[PW_W] ? '1 : width_sum[PW_W-1:0];
`else
    logic dead_time_unused;
    assign dead_time_unused = ^dead_time;
    assign eff_width        = pulse_width;
`endif

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = '0;
        stall_cnt_d = '0;
        if (!on) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = PRIME;
                PRIME: begin
                    if (prime_cnt_q == PC_W'(PRIME_CYCLES - 1)) state_d = RUN;
                    else prime_cnt_d = prime_cnt_q + 1'b1;
                end
                RUN: begin
                    // stall_cnt counts consecutive tick-free RUN cycles
                    if (crank_tick) stall_cnt_d = '0;
                    else if (stall_cnt_q == SC_W'(STALL_CYCLES - 1)) state_d = STALL;
                    else stall_cnt_d = stall_cnt_q + 1'b1;
                end
                STALL: if (crank_tick) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    assign stroke_edge = (stroke != stroke_q);
    assign run_next    = (state_d == RUN);

    for (genvar gi = 0; gi < NUM_CYL; gi++) begin : g_chan
        logic [1:0]      cyl_stroke;
        logic [PW_W-1:0] timer_q, timer_d;

        assign cyl_stroke    = stroke + phase_offset[2*gi +: 2];
        assign chan_open[gi] = (timer_q != '0);
        assign trig[gi]      = (state_q == RUN) && stroke_edge && (cyl_stroke == 2'b00);
        assign inj_out[gi]   = chan_open[gi];

        // Leaving RUN closes the channel on the same edge as the state change.
        always_comb begin
            timer_d = timer_q;
            if (!run_next)                      timer_d = '0;
            else if (trig[gi] && !chan_open[gi]) timer_d = eff_width;
            else if (chan_open[gi])             timer_d = timer_q - 1'b1;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) timer_q <= '0;
            else          timer_q <= timer_d;
        end
    end

    always_comb begin
        overrun_d = overrun_q | (trig & chan_open);
        if (!on) overrun_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            prime_cnt_q     <= '0;
            stall_cnt_q     <= '0;
            stroke_q        <= 2'b00;
            overrun_q       <= '0;
            fuel_pump_q     <= 1'b0;
            stalled_q       <= 1'b0;
            cal_injection_q <= 1'b0;
            update_table_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            prime_cnt_q     <= prime_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            stroke_q        <= stroke;
            overrun_q       <= overrun_d;
            fuel_pump_q     <= (state_d == PRIME) || (state_d == RUN);
            stalled_q       <= (state_d == STALL);
            cal_injection_q <= crank_tick && (stroke == 2'b00);
            update_table_q  <= crank_tick && (stroke == 2'b11);
        end
    end

    assign fuel_pump     = fuel_pump_q;
    assign stalled       = stalled_q;
    assign cal_injection = cal_injection_q;
    assign update_table  = update_table_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_multi_cyl_injection_ctrl.sv
// Bench for multi_cyl_injection_ctrl: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multi_cyl_injection_ctrl;
    localparam int NC    = 4;
    localparam int PW_W  = 16;
    localparam int PRIME = 20;
    localparam int STALL = 300;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_STALL = 3;

    logic            clk = 1'b0, reset_n = 1'b0, on = 1'b0, crank_tick = 1'b0;
    logic [1:0]      stroke = 2'b00;
    logic [2*NC-1:0] phase_offset = '0;
    logic [PW_W-1:0] pulse_width = '0, dead_time = '0;
    logic [NC-1:0]   inj_out, overrun;
    logic            fuel_pump, cal_injection, update_table, stalled;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_cyl_injection_ctrl #(
        .NUM_CYL(NC), .PW_W(PW_W), .PRIME_CYCLES(PRIME), .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .on(on), .stroke(stroke), .crank_tick(crank_tick),
        .phase_offset(phase_offset), .pulse_width(pulse_width), .dead_time(dead_time),
        .inj_out(inj_out), .fuel_pump(fuel_pump), .cal_injection(cal_injection),
        .update_table(update_table), .overrun(overrun), .stalled(stalled)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint eff_w();
`ifdef INJ_DEADTIME_EN
        longint s;
        s = longint'(pulse_width) + longint'(dead_time);
        return (s > 65535) ? 65535 : s;
`else
        return longint'(pulse_width);
`endif
    endfunction

    // Reference model: each channel is high after edge n while n <= open_until.
    int            m_mode = M_IDLE;
    longint        n_edge = 0;
    longint        prime_start = 0, last_tick = 0;
    longint        open_until [NC];
    logic [NC-1:0] m_ovr = '0;
    logic          m_cal = 1'b0, m_upd = 1'b0;
    logic [1:0]    m_prev = 2'b00;

    initial for (int i = 0; i < NC; i++) open_until[i] = -1;

    always @(posedge clk) begin : model
        int            nxt;
        logic [NC-1:0] exp_inj;
        n_edge++;
        if (!reset_n) begin
            m_mode = M_IDLE;
            m_ovr  = '0;
            m_cal  = 1'b0;
            m_upd  = 1'b0;
            m_prev = 2'b00;
            for (int i = 0; i < NC; i++) open_until[i] = -1;
        end else begin
            nxt = m_mode;
            if (!on) nxt = M_IDLE;
            else begin
                case (m_mode)
                    M_IDLE:  begin nxt = M_PRIME; prime_start = n_edge; end
                    M_PRIME: if (n_edge - prime_start == PRIME) begin nxt = M_RUN; last_tick = n_edge; end
                    M_RUN: begin
                        if (crank_tick) last_tick = n_edge;
                        else if (n_edge - last_tick == STALL) nxt = M_STALL;
                    end
                    default: if (crank_tick) begin nxt = M_PRIME; prime_start = n_edge; end
                endcase
            end
            for (int i = 0; i < NC; i++) begin
                if (m_mode == M_RUN && stroke != m_prev &&
                    ((int'(stroke) + int'(phase_offset[2*i +: 2])) % 4) == 0) begin
                    if (open_until[i] >= n_edge - 1) m_ovr[i] = 1'b1;
                    else open_until[i] = n_edge + eff_w() - 1;
                end
                if (nxt != M_RUN) open_until[i] = n_edge - 1;
            end
            if (!on) m_ovr = '0;
            m_prev = stroke;
            m_cal  = crank_tick && (stroke == 2'd0);
            m_upd  = crank_tick && (stroke == 2'd3);
            m_mode = nxt;
            for (int i = 0; i < NC; i++) exp_inj[i] = (n_edge <= open_until[i]);
            #1;
            if (reset_n) begin
                check("m_inj_out", inj_out, exp_inj);
                check("m_overrun", overrun, m_ovr);
                check("m_fuel_pump", fuel_pump, (m_mode == M_PRIME || m_mode == M_RUN));
                check("m_stalled", stalled, (m_mode == M_STALL));
                check("m_cal_injection", cal_injection, m_cal);
                check("m_update_table", update_table, m_upd);
            end
        end
    end

    int seq_stroke[4] = '{1, 2, 3, 0};
    int seq_cyl[4]    = '{2, 1, 3, 0};
    int tick_div[4]   = '{10, 40, 400, 15};

    initial begin
        int hi, other, cnt;
        logic [NC-1:0] want;
        repeat (3) @(negedge clk);
        check("reset_inj_out", inj_out, 0);
        check("reset_fuel_pump", fuel_pump, 0);
        check("reset_stalled", stalled, 0);
        check("reset_overrun", overrun, 0);
        check("reset_cal_upd", {cal_injection, update_table}, 0);
        reset_n = 1'b1;

        // Offsets {0,2,3,1}; stroke stepping 1,2,3,0 brings cylinders 2,1,3,0 to intake.
        on = 1'b1; pulse_width = 16'd10; phase_offset = 8'b01_11_10_00;
        repeat (PRIME + 3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            stroke = 2'(seq_stroke[s]); crank_tick = 1'b1;
            want = NC'(1) << seq_cyl[s];
            hi = 0; other = 0;
            for (int j = 0; j < 14; j++) begin
                @(negedge clk); crank_tick = 1'b0;
                if (inj_out == want) hi++;
                else if (inj_out != 0) other++;
            end
            check($sformatf("order_step%0d_width", s), hi, 10);
            check($sformatf("order_step%0d_other", s), other, 0);
        end

        // Zero width: no pulse, no overrun.
        pulse_width = 16'd0; stroke = 2'd1; cnt = 0;
        repeat (12) begin @(negedge clk); if (inj_out != 0) cnt++; end
        check("pw0_no_pulse", cnt, 0);
        check("pw0_no_overrun", overrun, 0);

        // Width 200 retriggered after ~100 cycles: pulse unchanged, overrun sticky.
        phase_offset = '0; stroke = 2'd2;
        repeat (2) @(negedge clk);
        pulse_width = 16'd200; stroke = 2'd0; cnt = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (inj_out[0]) cnt++;
            crank_tick = (j % 50 == 0);
            if (j == 100) stroke = 2'd1;
            if (j == 110) stroke = 2'd0;
        end
        crank_tick = 1'b0;
        check("long_pulse_width", cnt, 200);
        check("overrun_set", overrun, 4'hF);

        // on dropped mid-pulse.
        pulse_width = 16'd30; stroke = 2'd3;
        repeat (2) @(negedge clk);
        stroke = 2'd0;
        repeat (5) @(negedge clk);
        check("midpulse_open", inj_out, 4'hF);
        check("overrun_still_set", overrun, 4'hF);
        on = 1'b0;
        @(negedge clk);
        check("on_drop_inj", inj_out, 0);
        check("on_drop_overrun", overrun, 0);
        check("on_drop_pump", fuel_pump, 0);

        // Prime then stall with no ticks: pump high for PRIME+STALL cycles.
        on = 1'b1; cnt = 0;
        for (int j = 0; j < 1000 && !stalled; j++) begin
            @(negedge clk);
            if (fuel_pump) cnt++;
        end
        check("stall_reached", stalled, 1);
        check("prime_plus_run_pump", cnt, PRIME + STALL);
        check("stall_pump_off", fuel_pump, 0);
        crank_tick = 1'b1;
        @(negedge clk); crank_tick = 1'b0;
        check("stall_restart_pump", fuel_pump, 1);
        check("stall_restart_stalled", stalled, 0);

        // Asynchronous reset in the middle of a pulse.
        repeat (PRIME + 2) @(negedge clk);
        pulse_width = 16'd25; stroke = 2'd1;
        @(negedge clk); stroke = 2'd0;
        repeat (4) @(negedge clk);
        check("pre_reset_open", inj_out, 4'hF);
        reset_n = 1'b0;
        #1;
        check("async_reset_inj", inj_out, 0);
        check("async_reset_pump", fuel_pump, 0);
        @(negedge clk); reset_n = 1'b1;

`ifdef INJ_DEADTIME_EN
        repeat (PRIME + 3) @(negedge clk);
        stroke = 2'd1;
        @(negedge clk);
        pulse_width = 16'hFFF0; dead_time = 16'h0020; stroke = 2'd0; cnt = 0;
        for (int j = 0; j < 65600; j++) begin
            @(negedge clk);
            if (inj_out[0]) cnt++;
            crank_tick = (j % 100 == 0);
        end
        crank_tick = 1'b0;
        check("deadtime_saturated_width", cnt, 65535);
`endif

        for (int seg = 0; seg < 4; seg++) begin
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                crank_tick = ($urandom_range(0, tick_div[seg] - 1) == 0);
                if (crank_tick && $urandom_range(0, 3) != 0) stroke = stroke + 2'd1;
                else if ($urandom_range(0, 199) == 0) stroke = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) pulse_width = 16'($urandom_range(0, 70));
                dead_time = 16'($urandom_range(0, 15));
                if ($urandom_range(0, 999) == 0) phase_offset = 8'($urandom);
                if (!on) on = ($urandom_range(0, 9) == 0);
                else     on = ($urandom_range(0, 1499) != 0);
            end
        end

        crank_tick = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
